// File: rtl/exe_stage_md.sv
// Execute stage with ALU, optionally pipelined multiplier, iterative divider and sub-word stores.
// Define EXE_PIPE_MUL_EN to register the multiplier product (adds one stall cycle per MUL).
module exe_stage_md #(
   parameter int DATA_W = 32,
   parameter int SB_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ms_allowin,
   output logic              es_allowin,
   input  logic              es_flush,
   input  logic              ds_to_es_valid,
   input  logic [1:0]        ds_op_class,
   input  logic [11:0]       ds_alu_op,
   input  logic [1:0]        ds_md_op,
   input  logic [DATA_W-1:0] ds_src1,
   input  logic [DATA_W-1:0] ds_src2,
   input  logic [DATA_W-1:0] ds_store_data,
   input  logic              ds_mem_we,
   input  logic              ds_res_from_mem,
   input  logic [1:0]        ds_mem_size,
   input  logic              ds_gr_we,
   input  logic [4:0]        ds_dest,
   input  logic [31:0]       ds_pc,
   output logic              es_to_ms_valid,
   output logic [DATA_W-1:0] es_result,
   output logic              es_res_from_mem,
   output logic              es_gr_we,
   output logic [1:0]        es_mem_size,
   output logic [4:0]        es_dest,
   output logic [31:0]       es_pc,
   output logic              es_ale,
   output logic              data_sram_en,
   output logic [SB_W-1:0]   data_sram_we,
   output logic [31:0]       data_sram_addr,
   output logic [DATA_W-1:0] data_sram_wdata
);

   localparam int SH_W   = $clog2(DATA_W);
   localparam int LANE_W = $clog2(SB_W);
   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [1:0] CLS_ALU = 2'd0;
   localparam logic [1:0] CLS_MUL = 2'd1;
   localparam logic [1:0] CLS_DIV = 2'd2;
   localparam logic [1:0] CLS_MEM = 2'd3;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // One-hot ALU: add sub slt sltu and nor or xor sll srl sra lui
   function automatic logic [DATA_W-1:0] alu_f(input logic [11:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
      logic [SH_W-1:0] sh;
      sh = b[SH_W-1:0];
      return ({DATA_W{op[0]}}  & (a + b))
           | ({DATA_W{op[1]}}  & (a - b))
           | ({DATA_W{op[2]}}  & {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))})
           | ({DATA_W{op[3]}}  & {{(DATA_W-1){1'b0}}, (a < b)})
           | ({DATA_W{op[4]}}  & (a & b))
           | ({DATA_W{op[5]}}  & ~(a | b))
           | ({DATA_W{op[6]}}  & (a | b))
           | ({DATA_W{op[7]}}  & (a ^ b))
           | ({DATA_W{op[8]}}  & (a << sh))
           | ({DATA_W{op[9]}}  & (a >> sh))
           | ({DATA_W{op[10]}} & $unsigned($signed(a) >>> sh))
           | ({DATA_W{op[11]}} & b);
   endfunction

   logic              es_valid_r;
   logic [1:0]        op_class_r;
   logic [11:0]       alu_op_r;
   logic [1:0]        md_op_r;
   logic [DATA_W-1:0] src1_r, src2_r, store_data_r;
   logic              mem_we_r, res_from_mem_r, gr_we_r;
   logic [1:0]        mem_size_r;
   logic [4:0]        dest_r;
   logic [31:0]       pc_r;

   logic              es_ready_go_s, handoff_s;
   logic [DATA_W-1:0] alu_res_s;

   div_state_e        div_state_r;
   logic [CNT_W-1:0]  count_r;
   logic [DATA_W-1:0] quo_r, rem_r, dvsr_r;
   logic              neg_q_r, neg_r_r;

   assign alu_res_s      = alu_f(alu_op_r, src1_r, src2_r);
   assign handoff_s      = es_valid_r && es_ready_go_s && ms_allowin;
   assign es_allowin     = !es_valid_r || (es_ready_go_s && ms_allowin);
   assign es_to_ms_valid = es_valid_r && es_ready_go_s && !es_flush;

   // Stage valid bit: flush wins over acceptance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         es_valid_r <= 1'b0;
      end else if (es_flush) begin
         es_valid_r <= 1'b0;
      end else if (es_allowin) begin
         es_valid_r <= ds_to_es_valid;
      end
   end

   // Payload capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_class_r     <= 2'd0;
         alu_op_r       <= 12'd0;
         md_op_r        <= 2'd0;
         src1_r         <= {DATA_W{1'b0}};
         src2_r         <= {DATA_W{1'b0}};
         store_data_r   <= {DATA_W{1'b0}};
         mem_we_r       <= 1'b0;
         res_from_mem_r <= 1'b0;
         mem_size_r     <= 2'd0;
         gr_we_r        <= 1'b0;
         dest_r         <= 5'd0;
         pc_r           <= 32'd0;
      end else if (ds_to_es_valid && es_allowin && !es_flush) begin
         op_class_r     <= ds_op_class;
         alu_op_r       <= ds_alu_op;
         md_op_r        <= ds_md_op;
         src1_r         <= ds_src1;
         src2_r         <= ds_src2;
         store_data_r   <= ds_store_data;
         mem_we_r       <= ds_mem_we;
         res_from_mem_r <= ds_res_from_mem;
         mem_size_r     <= ds_mem_size;
         gr_we_r        <= ds_gr_we;
         dest_r         <= ds_dest;
         pc_r           <= ds_pc;
      end
   end

   // ---------------- multiplier ----------------
   logic                mul_sgn_s;
   logic [2*DATA_W+1:0] mul_a_s, mul_b_s, mul_prod_s;
   logic [1:0]          mul_unused_s;
   logic [DATA_W-1:0]   mul_comb_s, mul_val_s;
   logic                mul_ready_s;

   // Operands are sign/zero extended so one unsigned multiply serves all three forms
   always_comb begin
      mul_sgn_s    = (md_op_r == 2'd1);
      mul_a_s      = {{(DATA_W+2){mul_sgn_s & src1_r[DATA_W-1]}}, src1_r};
      mul_b_s      = {{(DATA_W+2){mul_sgn_s & src2_r[DATA_W-1]}}, src2_r};
      mul_prod_s   = mul_a_s * mul_b_s;
      mul_unused_s = mul_prod_s[2*DATA_W+1:2*DATA_W];
      case (md_op_r)
         2'd0:    mul_comb_s = mul_prod_s[DATA_W-1:0];
         2'd1:    mul_comb_s = mul_prod_s[2*DATA_W-1:DATA_W];
         2'd2:    mul_comb_s = mul_prod_s[2*DATA_W-1:DATA_W];
         default: mul_comb_s = mul_prod_s[DATA_W-1:0];
      endcase
   end

`ifdef EXE_PIPE_MUL_EN
   logic              mul_done_r;
   logic [DATA_W-1:0] mul_res_r;

   // Product register, held until handoff
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mul_done_r <= 1'b0;
         mul_res_r  <= {DATA_W{1'b0}};
      end else if (es_flush) begin
         mul_done_r <= 1'b0;
         mul_res_r  <= {DATA_W{1'b0}};
      end else if (handoff_s) begin
         mul_done_r <= 1'b0;
      end else if (es_valid_r && (op_class_r == CLS_MUL) && !mul_done_r) begin
         mul_done_r <= 1'b1;
         mul_res_r  <= mul_comb_s;
      end
   end

   assign mul_ready_s = mul_done_r;
   assign mul_val_s   = mul_res_r;
`else
   assign mul_ready_s = 1'b1;
   assign mul_val_s   = mul_comb_s;
`endif

   // ---------------- divider ----------------
   logic              div_signed_s, a_neg_s, b_neg_s, q_bit_s;
   logic [DATA_W-1:0] a_abs_s, b_abs_s, rem_nxt_s, q_fix_s, r_fix_s, div_val_s;
   logic [DATA_W:0]   rem_sh_s, diff_s;

   // Restoring step and sign correction
   always_comb begin
      div_signed_s = ~md_op_r[1];
      a_neg_s      = div_signed_s & src1_r[DATA_W-1];
      b_neg_s      = div_signed_s & src2_r[DATA_W-1];
      a_abs_s      = a_neg_s ? (-src1_r) : src1_r;
      b_abs_s      = b_neg_s ? (-src2_r) : src2_r;
      rem_sh_s     = {rem_r, quo_r[DATA_W-1]};
      diff_s       = rem_sh_s - {1'b0, dvsr_r};
      q_bit_s      = ~diff_s[DATA_W];
      rem_nxt_s    = q_bit_s ? diff_s[DATA_W-1:0] : rem_sh_s[DATA_W-1:0];
      if (src2_r == {DATA_W{1'b0}}) begin
         q_fix_s = {DATA_W{1'b1}};
         r_fix_s = src1_r;
      end else begin
         q_fix_s = neg_q_r ? (-quo_r) : quo_r;
         r_fix_s = neg_r_r ? (-rem_r) : rem_r;
      end
      div_val_s = md_op_r[0] ? r_fix_s : q_fix_s;
   end

   // Divider FSM: IDLE latches operands, BUSY iterates DATA_W times, DONE holds result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_state_r <= DIV_IDLE;
         count_r     <= {CNT_W{1'b0}};
         quo_r       <= {DATA_W{1'b0}};
         rem_r       <= {DATA_W{1'b0}};
         dvsr_r      <= {DATA_W{1'b0}};
         neg_q_r     <= 1'b0;
         neg_r_r     <= 1'b0;
      end else if (es_flush) begin
         div_state_r <= DIV_IDLE;
      end else begin
         case (div_state_r)
            DIV_IDLE: begin
               if (es_valid_r && (op_class_r == CLS_DIV)) begin
                  div_state_r <= DIV_BUSY;
                  count_r     <= CNT_INIT;
                  quo_r       <= a_abs_s;
                  rem_r       <= {DATA_W{1'b0}};
                  dvsr_r      <= b_abs_s;
                  neg_q_r     <= a_neg_s ^ b_neg_s;
                  neg_r_r     <= a_neg_s;
               end
            end
            DIV_BUSY: begin
               rem_r   <= rem_nxt_s;
               quo_r   <= {quo_r[DATA_W-2:0], q_bit_s};
               count_r <= count_r - CNT_ONE;
               if (count_r == CNT_ONE) begin
                  div_state_r <= DIV_DONE;
               end
            end
            DIV_DONE: begin
               if (handoff_s) begin
                  div_state_r <= DIV_IDLE;
               end
            end
            default: div_state_r <= DIV_IDLE;
         endcase
      end
   end

   // ---------------- memory access ----------------
   logic              is_mem_s, misalign_s;
   logic [SB_W-1:0]   size_mask_s;
   logic [DATA_W-1:0] wdata_s;

   // Byte-lane mask, alignment check and lane replication of the store value
   always_comb begin
      size_mask_s = {SB_W{1'b0}};
      case (mem_size_r)
         2'd0: begin
            size_mask_s[0] = 1'b1;
            misalign_s     = 1'b0;
            wdata_s        = {SB_W{store_data_r[7:0]}};
         end
         2'd1: begin
            size_mask_s[1:0] = 2'b11;
            misalign_s       = alu_res_s[0];
            wdata_s          = {(SB_W/2){store_data_r[15:0]}};
         end
         2'd2: begin
            size_mask_s[3:0] = 4'hF;
            misalign_s       = (alu_res_s[1:0] != 2'd0);
            wdata_s          = {(DATA_W/32){store_data_r[31:0]}};
         end
         default: begin
            size_mask_s = {SB_W{1'b1}};
            misalign_s  = (DATA_W == 32) || (alu_res_s[2:0] != 3'd0);
            wdata_s     = store_data_r;
         end
      endcase
   end

   assign is_mem_s        = es_valid_r && (op_class_r == CLS_MEM);
   assign es_ale          = is_mem_s && misalign_s;
   assign data_sram_en    = is_mem_s && !misalign_s && !es_flush;
   assign data_sram_we    = (is_mem_s && mem_we_r && !misalign_s && ms_allowin && !es_flush)
                            ? (size_mask_s << alu_res_s[LANE_W-1:0]) : {SB_W{1'b0}};
   assign data_sram_addr  = alu_res_s[31:0];
   assign data_sram_wdata = wdata_s;

   // Ready-go and result select per op class
   always_comb begin
      es_ready_go_s = 1'b1;
      es_result     = alu_res_s;
      case (op_class_r)
         CLS_ALU: begin
            es_ready_go_s = 1'b1;
            es_result     = alu_res_s;
         end
         CLS_MUL: begin
            es_ready_go_s = mul_ready_s;
            es_result     = mul_val_s;
         end
         CLS_DIV: begin
            es_ready_go_s = (div_state_r == DIV_DONE);
            es_result     = div_val_s;
         end
         CLS_MEM: begin
            es_ready_go_s = 1'b1;
            es_result     = alu_res_s;
         end
         default: begin
            es_ready_go_s = 1'b1;
            es_result     = alu_res_s;
         end
      endcase
   end

   assign es_res_from_mem = res_from_mem_r;
   assign es_gr_we        = gr_we_r;
   assign es_mem_size     = mem_size_r;
   assign es_dest         = dest_r;
   assign es_pc           = pc_r;

endmodule

// File: tb/tb_exe_stage_md.sv
// Directed bench for exe_stage_md (DATA_W=32): ALU, MUL, DIV, stores, stalls and flush.
module tb_exe_stage_md;

   logic        clk = 1'b0;
   logic        reset;
   logic        ms_allowin, es_allowin, es_flush, ds_to_es_valid;
   logic [1:0]  ds_op_class, ds_md_op, ds_mem_size;
   logic [11:0] ds_alu_op;
   logic [31:0] ds_src1, ds_src2, ds_store_data, ds_pc;
   logic        ds_mem_we, ds_res_from_mem, ds_gr_we;
   logic [4:0]  ds_dest;
   logic        es_to_ms_valid, es_res_from_mem, es_gr_we, es_ale;
   logic [31:0] es_result, es_pc, data_sram_addr, data_sram_wdata;
   logic [1:0]  es_mem_size;
   logic [4:0]  es_dest;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;

   int checks   = 0;
   int failures = 0;

   exe_stage_md #(.DATA_W(32), .SB_W(4)) dut (
      .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
      .es_flush(es_flush), .ds_to_es_valid(ds_to_es_valid), .ds_op_class(ds_op_class),
      .ds_alu_op(ds_alu_op), .ds_md_op(ds_md_op), .ds_src1(ds_src1), .ds_src2(ds_src2),
      .ds_store_data(ds_store_data), .ds_mem_we(ds_mem_we), .ds_res_from_mem(ds_res_from_mem),
      .ds_mem_size(ds_mem_size), .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ds_pc(ds_pc),
      .es_to_ms_valid(es_to_ms_valid), .es_result(es_result), .es_res_from_mem(es_res_from_mem),
      .es_gr_we(es_gr_we), .es_mem_size(es_mem_size), .es_dest(es_dest), .es_pc(es_pc),
      .es_ale(es_ale), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [1:0] cls, input logic [11:0] aop, input logic [1:0] md,
                          input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] sd,
                          input logic we, input logic rfm, input logic [1:0] size);
      ds_op_class     = cls;
      ds_alu_op       = aop;
      ds_md_op        = md;
      ds_src1         = s1;
      ds_src2         = s2;
      ds_store_data   = sd;
      ds_mem_we       = we;
      ds_res_from_mem = rfm;
      ds_mem_size     = size;
      ds_gr_we        = ~we;
      ds_to_es_valid  = 1'b1;
   endtask

   task automatic accept();
      @(posedge clk);
      #1;
      ds_to_es_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic [31:0] exp);
      int cyc;
      cyc = 0;
      while (es_to_ms_valid !== 1'b1 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, " latency"}, 64'(cyc), 64'd33);
      check({tag, " result"}, {32'd0, es_result}, {32'd0, exp});
   endtask

   task automatic run_div(input string tag, input logic [1:0] md, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      present(2'd2, 12'h000, md, a, b, 32'd0, 1'b0, 1'b0, 2'd0);
      accept();
      wait_done(tag, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic run_mul(input string tag, input logic [1:0] md, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      present(2'd1, 12'h000, md, a, b, 32'd0, 1'b0, 1'b0, 2'd0);
      accept();
`ifdef EXE_PIPE_MUL_EN
      check({tag, " c0 valid"}, {63'd0, es_to_ms_valid}, 64'd0);
      @(posedge clk);
      #1;
`endif
      check({tag, " valid"}, {63'd0, es_to_ms_valid}, 64'd1);
      check({tag, " result"}, {32'd0, es_result}, {32'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic run_st(input string tag, input logic [31:0] off, input logic [31:0] sd,
                         input logic [1:0] size, input logic [3:0] exp_we,
                         input logic [31:0] exp_wd, input logic exp_ale);
      present(2'd3, 12'h001, 2'd0, 32'h0000_1000, off, sd, 1'b1, 1'b0, size);
      accept();
      check({tag, " we"}, {60'd0, data_sram_we}, {60'd0, exp_we});
      check({tag, " ale"}, {63'd0, es_ale}, {63'd0, exp_ale});
      check({tag, " en"}, {63'd0, data_sram_en}, {63'd0, ~exp_ale});
      if (!exp_ale) begin
         check({tag, " wdata"}, {32'd0, data_sram_wdata}, {32'd0, exp_wd});
         check({tag, " addr"}, {32'd0, data_sram_addr}, {32'd0, 32'h0000_1000 + off});
      end else begin
         check({tag, " valid"}, {63'd0, es_to_ms_valid}, 64'd1);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired before end of sequence");
      $fatal(1, "timeout");
   end

   initial begin
      int seen;
      reset = 1'b1;
      ms_allowin = 1'b1;
      es_flush = 1'b0;
      ds_to_es_valid = 1'b0;
      ds_dest = 5'd5;
      ds_pc = 32'h1C00_0010;
      present(2'd0, 12'h000, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
      ds_to_es_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst allowin", {63'd0, es_allowin}, 64'd1);
      check("rst to_ms_valid", {63'd0, es_to_ms_valid}, 64'd0);
      check("rst sram_en", {63'd0, data_sram_en}, 64'd0);
      check("rst sram_we", {60'd0, data_sram_we}, 64'd0);
      check("rst result", {32'd0, es_result}, 64'd0);
      check("rst pc", {32'd0, es_pc}, 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // ALU
      present(2'd0, 12'h001, 2'd0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 2'd0);
      accept();
      check("add valid", {63'd0, es_to_ms_valid}, 64'd1);
      check("add result", {32'd0, es_result}, 64'd7);
      check("add dest", {59'd0, es_dest}, 64'd5);
      check("add pc", {32'd0, es_pc}, 64'h1C00_0010);
      check("add gr_we", {63'd0, es_gr_we}, 64'd1);
      @(posedge clk);
      #1;
      check("add drained", {63'd0, es_to_ms_valid}, 64'd0);
      present(2'd0, 12'h002, 2'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 2'd0);
      accept();
      check("sub result", {32'd0, es_result}, 64'hFFFF_FFFE);
      @(posedge clk);
      #1;

      // MUL
      run_mul("mulh signed", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      run_mul("mul low", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      run_mul("mulh unsigned", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_mul("mul low2", 2'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);

      // Flush in cycle 10 of a DIV
      present(2'd2, 12'h000, 2'd0, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 2'd0);
      accept();
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      es_flush = 1'b1;
      #1;
      check("flush cycle valid", {63'd0, es_to_ms_valid}, 64'd0);
      @(posedge clk);
      #1;
      es_flush = 1'b0;
      ms_allowin = 1'b0;
      #1;
      check("flush empties stage", {63'd0, es_allowin}, 64'd1);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (es_to_ms_valid) seen++;
      end
      check("flush no result", 64'(seen), 64'd0);
      ms_allowin = 1'b1;
      present(2'd0, 12'h001, 2'd0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 2'd0);
      accept();
      check("post-flush add valid", {63'd0, es_to_ms_valid}, 64'd1);
      check("post-flush add result", {32'd0, es_result}, 64'd7);
      @(posedge clk);
      #1;

      // DIV
      run_div("div 100/7", 2'd0, 32'd100, 32'd7, 32'd14);
      run_div("div -7/2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_div("mod -7/2", 2'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_div("div 5/0", 2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF);
      run_div("mod 5/0", 2'd1, 32'd5, 32'd0, 32'd5);
      run_div("div min/-1", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_div("mod min/-1", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run_div("divu", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);

      // mod held in DONE with MS stalled
      ms_allowin = 1'b0;
      present(2'd2, 12'h000, 2'd1, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 2'd0);
      accept();
      wait_done("mod 100/7", 32'd2);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("mod hold valid", {63'd0, es_to_ms_valid}, 64'd1);
      check("mod hold result", {32'd0, es_result}, 64'd2);
      check("mod hold allowin", {63'd0, es_allowin}, 64'd0);
      ms_allowin = 1'b1;

      // back-to-back: second DIV enters on the handoff edge
      present(2'd2, 12'h000, 2'd3, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 2'd0);
      accept();
      wait_done("b2b modu", 32'd2);
      present(2'd2, 12'h000, 2'd0, 32'd200, 32'd7, 32'd0, 1'b0, 1'b0, 2'd0);
      accept();
      wait_done("b2b div", 32'd28);
      @(posedge clk);
      #1;

      // Stores and load
      run_st("st.b", 32'd3, 32'h0000_00AB, 2'd0, 4'b1000, 32'hABAB_ABAB, 1'b0);
      run_st("st.h", 32'd2, 32'h0000_1234, 2'd1, 4'b1100, 32'h1234_1234, 1'b0);
      run_st("st.w mis", 32'd2, 32'h1111_2222, 2'd2, 4'b0000, 32'd0, 1'b1);
      present(2'd3, 12'h001, 2'd0, 32'h0000_1000, 32'd4, 32'd0, 1'b0, 1'b1, 2'd2);
      accept();
      check("ld.w en", {63'd0, data_sram_en}, 64'd1);
      check("ld.w we", {60'd0, data_sram_we}, 64'd0);
      check("ld.w rfm", {63'd0, es_res_from_mem}, 64'd1);
      check("ld.w size", {62'd0, es_mem_size}, 64'd2);
      @(posedge clk);
      #1;

      // Store stalled by MS for five cycles writes exactly once
      ms_allowin = 1'b0;
      present(2'd3, 12'h001, 2'd0, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd2);
      accept();
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (data_sram_we !== 4'h0) seen++;
         @(posedge clk);
         #1;
      end
      check("held st we quiet", 64'(seen), 64'd0);
      check("held st en", {63'd0, data_sram_en}, 64'd1);
      ms_allowin = 1'b1;
      #1;
      check("held st we", {60'd0, data_sram_we}, 64'hF);
      check("held st wdata", {32'd0, data_sram_wdata}, 64'hDEAD_BEEF);
      @(posedge clk);
      #1;
      check("held st after we", {60'd0, data_sram_we}, 64'd0);
      check("held st after valid", {63'd0, es_to_ms_valid}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
